// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer
//  Description : Round/score sequencer for a two-sided ball game. Tracks the
//                IDLE/PLAY/SCORED/OVER flow, keeps both scores, decides who
//                serves next and times the between-round pause in frames.
//  Revision    : 1.0  initial release
// ============================================================================
module game_sequencer #(
  parameter logic [11:0] GROUND_Y     = 12'd200,
  parameter logic [11:0] NET_X        = 12'd160,
  parameter logic [11:0] BALL_HALF    = 12'd15,
  parameter logic [2:0]  WIN_SCORE    = 3'd5,
  parameter logic [7:0]  PAUSE_FRAMES = 8'd60
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  user_btn,
  input  logic        VGA_VSYNC,
  input  logic [11:0] ball_x_position,
  input  logic [11:0] ball_y_position,
  output logic [1:0]  Game_state,
  output logic [2:0]  player_score,
  output logic [2:0]  computer_score,
  output logic        round_reset,
  output logic        serve_right,
  output logic        frame_tick
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_play   = 2'd1;
  localparam logic [1:0] c_st_scored = 2'd2;
  localparam logic [1:0] c_st_over   = 2'd3;

  logic [1:0]  r_state;
  logic        r_vsync_prev;
  logic        r_btn_prev;
  logic        r_press;
  logic        r_frame_tick;
  logic [7:0]  r_pause_cnt;
  logic [2:0]  r_player_score;
  logic [2:0]  r_computer_score;
  logic        r_serve_right;
  logic        r_round_reset;

  logic [1:0]  w_next_state;
  logic [11:0] w_ball_centre;
  logic        w_landed;
  logic        w_right_side;
  logic        w_pause_done;
  logic        w_game_won;
  logic [7:0]  w_pause_cnt_nxt;
  logic [2:0]  w_player_score_nxt;
  logic [2:0]  w_computer_score_nxt;
  logic        w_serve_right_nxt;
  logic        w_round_reset_nxt;

  // Ball position qualifiers; the centre sum deliberately wraps at 12 bits.
  assign w_ball_centre = ball_x_position + BALL_HALF;
  assign w_landed      = (ball_y_position >= GROUND_Y);
  assign w_right_side  = (w_ball_centre >= NET_X);
  assign w_pause_done  = r_frame_tick && (r_pause_cnt == (PAUSE_FRAMES - 8'd1));
  assign w_game_won    = (r_player_score == WIN_SCORE) || (r_computer_score == WIN_SCORE);

  // State register plus edge-detect history and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state          <= c_st_idle;
      r_vsync_prev     <= 1'b1;
      r_btn_prev       <= 1'b0;
      r_press          <= 1'b0;
      r_frame_tick     <= 1'b0;
      r_pause_cnt      <= 8'd0;
      r_player_score   <= 3'd0;
      r_computer_score <= 3'd0;
      r_serve_right    <= 1'b0;
      r_round_reset    <= 1'b0;
    end else begin
      r_state          <= w_next_state;
      r_vsync_prev     <= VGA_VSYNC;
      r_btn_prev       <= user_btn[0];
      r_press          <= user_btn[0] & ~r_btn_prev;
      r_frame_tick     <= r_vsync_prev & ~VGA_VSYNC;
      r_pause_cnt      <= w_pause_cnt_nxt;
      r_player_score   <= w_player_score_nxt;
      r_computer_score <= w_computer_score_nxt;
      r_serve_right    <= w_serve_right_nxt;
      r_round_reset    <= w_round_reset_nxt;
    end
  end

  // Next-state decision; press and frame_tick are the registered pulses.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:   if (r_press) w_next_state = c_st_play;
      c_st_play:   if (w_landed) w_next_state = c_st_scored;
      c_st_scored: if (w_pause_done) w_next_state = w_game_won ? c_st_over : c_st_play;
      c_st_over:   if (r_press) w_next_state = c_st_idle;
      default:     w_next_state = c_st_idle;
    endcase
  end

  // Next values of scores, serve side, pause counter and round_reset pulse.
  always_comb begin
    w_pause_cnt_nxt      = r_pause_cnt;
    w_player_score_nxt   = r_player_score;
    w_computer_score_nxt = r_computer_score;
    w_serve_right_nxt    = r_serve_right;
    w_round_reset_nxt    = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (r_press) w_round_reset_nxt = 1'b1;
      end
      c_st_play: begin
        if (w_landed) begin
          w_pause_cnt_nxt = 8'd0;
          if (w_right_side) begin
            // Ball came down on the player's half: the computer scores.
            if (r_computer_score < WIN_SCORE) w_computer_score_nxt = r_computer_score + 3'd1;
            w_serve_right_nxt = 1'b0;
          end else begin
            if (r_player_score < WIN_SCORE) w_player_score_nxt = r_player_score + 3'd1;
            w_serve_right_nxt = 1'b1;
          end
        end
      end
      c_st_scored: begin
        if (w_pause_done) begin
          if (!w_game_won) w_round_reset_nxt = 1'b1;
        end else if (r_frame_tick) begin
          w_pause_cnt_nxt = r_pause_cnt + 8'd1;
        end
      end
      c_st_over: begin
        if (r_press) begin
          w_player_score_nxt   = 3'd0;
          w_computer_score_nxt = 3'd0;
          w_serve_right_nxt    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign Game_state     = r_state;
  assign player_score   = r_player_score;
  assign computer_score = r_computer_score;
  assign round_reset    = r_round_reset;
  assign serve_right    = r_serve_right;
  assign frame_tick     = r_frame_tick;

  // Unused buttons are reserved for future game controls.
  logic w_unused;
  assign w_unused = ^user_btn[3:1];

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_sequencer
//  Description : Randomised scoreboard bench for game_sequencer with a
//                frame/round level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_game_sequencer;

  logic        clk;
  logic        reset_n;
  logic [3:0]  user_btn;
  logic        VGA_VSYNC;
  logic [11:0] ball_x_position;
  logic [11:0] ball_y_position;
  logic [1:0]  Game_state;
  logic [2:0]  player_score;
  logic [2:0]  computer_score;
  logic        round_reset;
  logic        serve_right;
  logic        frame_tick;

  game_sequencer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .user_btn        (user_btn),
    .VGA_VSYNC       (VGA_VSYNC),
    .ball_x_position (ball_x_position),
    .ball_y_position (ball_y_position),
    .Game_state      (Game_state),
    .player_score    (player_score),
    .computer_score  (computer_score),
    .round_reset     (round_reset),
    .serve_right     (serve_right),
    .frame_tick      (frame_tick)
  );

  typedef struct packed {
    logic [1:0] state;
    logic [2:0] pscore;
    logic [2:0] cscore;
    logic       rr;
    logic       serve;
    logic       ft;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   model_run = 1'b1;

  // Reference model variables (game-level view)
  int m_phase;      // 0 idle, 1 play, 2 scored, 3 over
  int m_pscore, m_cscore, m_serve, m_rr, m_ft, m_press, m_frames;
  int m_vs_last, m_btn_last;
  int n_over_seen = 0, n_rounds = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluates the game rules once per rising edge.
  initial begin
    int   prev_ft, prev_press, centre;
    bit   landed, right;
    exp_t e;
    forever begin
      @(posedge clk);
      if (!model_run) continue;
      if (!reset_n) begin
        m_phase = 0; m_pscore = 0; m_cscore = 0; m_serve = 0; m_rr = 0;
        m_ft = 0; m_press = 0; m_frames = 0; m_vs_last = 1; m_btn_last = 0;
      end else begin
        prev_ft    = m_ft;
        prev_press = m_press;
        m_ft       = (m_vs_last == 1 && VGA_VSYNC == 1'b0) ? 1 : 0;
        m_press    = (m_btn_last == 0 && user_btn[0] == 1'b1) ? 1 : 0;
        m_vs_last  = int'(VGA_VSYNC);
        m_btn_last = int'(user_btn[0]);
        m_rr       = 0;
        centre     = (int'(ball_x_position) + 15) % 4096;
        landed     = (int'(ball_y_position) >= 200);
        right      = (centre >= 160);
        if (m_phase == 0) begin
          if (prev_press == 1) begin m_phase = 1; m_rr = 1; end
        end else if (m_phase == 1) begin
          if (landed) begin
            if (right) begin
              m_cscore = (m_cscore + 1 > 5) ? 5 : m_cscore + 1;
              m_serve  = 0;
            end else begin
              m_pscore = (m_pscore + 1 > 5) ? 5 : m_pscore + 1;
              m_serve  = 1;
            end
            m_frames = 0;
            m_phase  = 2;
          end
        end else if (m_phase == 2) begin
          if (prev_ft == 1) begin
            m_frames++;
            if (m_frames == 60) begin
              n_rounds++;
              if (m_pscore == 5 || m_cscore == 5) begin m_phase = 3; n_over_seen++; end
              else begin m_phase = 1; m_rr = 1; end
            end
          end
        end else begin
          if (prev_press == 1) begin
            m_pscore = 0; m_cscore = 0; m_serve = 0; m_phase = 0;
          end
        end
      end
      e.state  = 2'(m_phase);
      e.pscore = 3'(m_pscore);
      e.cscore = 3'(m_cscore);
      e.rr     = 1'(m_rr);
      e.serve  = 1'(m_serve);
      e.ft     = 1'(m_ft);
      q_exp.push_back(e);
    end
  end

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        check("Game_state",     int'(Game_state),     int'(e.state));
        check("player_score",   int'(player_score),   int'(e.pscore));
        check("computer_score", int'(computer_score), int'(e.cscore));
        check("round_reset",    int'(round_reset),    int'(e.rr));
        check("serve_right",    int'(serve_right),    int'(e.serve));
        check("frame_tick",     int'(frame_tick),     int'(e.ft));
      end
    end
  end

  // Randomised stimulus, driven on the falling edge.
  initial begin
    int btn_hold;
    int sel;
    reset_n         = 1'b0;
    user_btn        = 4'd0;
    VGA_VSYNC       = 1'b1;
    ball_x_position = 12'd0;
    ball_y_position = 12'd0;
    btn_hold        = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      @(negedge clk);
      reset_n = ($urandom_range(0, 4999) == 0) ? 1'b0 : 1'b1;
      if (btn_hold == 0) begin
        user_btn[0] = ~user_btn[0];
        btn_hold    = $urandom_range(1, 120);
      end else begin
        btn_hold--;
      end
      user_btn[3:1] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) VGA_VSYNC = ~VGA_VSYNC;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       ball_x_position = 12'd144;
        1:       ball_x_position = 12'd145;
        2:       ball_x_position = 12'd4090;
        3:       ball_x_position = 12'd150;
        default: ball_x_position = 12'($urandom_range(0, 319));
      endcase
      sel = $urandom_range(0, 39);
      if (sel == 0)      ball_y_position = 12'd200;
      else if (sel == 1) ball_y_position = 12'd199;
      else if (sel == 2) ball_y_position = 12'($urandom_range(201, 239));
      else               ball_y_position = 12'($urandom_range(0, 198));
    end
    repeat (2) @(negedge clk);
    model_run = 1'b0;
    repeat (2) @(negedge clk);
    check("queue_drained", q_exp.size(), 0);
    $display("Info: rounds completed %0d, games ended %0d", n_rounds, n_over_seen);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
